// File: rtl/pc_ir_fetch_pkg.sv
// Shared CPU definitions for the fetch side: PC-source encodings, fetch FSM states
// and the instruction memory size.
package pc_ir_fetch_pkg;

  typedef enum logic [1:0] {
    PCSRC_NEXT   = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_REG    = 2'b10,
    PCSRC_JUMP   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StFault = 2'b10
  } fetch_state_e;

  // Also used to size the instruction memory itself.
  localparam int unsigned IMEM_SIZE = 100;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC generation and fetch-target legality check.
module next_pc_calc
  import pc_ir_fetch_pkg::*;
#(
  parameter int unsigned ImemBytes = IMEM_SIZE
) (
  input  logic [31:0] pc_i,
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] immediate_i,
  input  logic [31:0] regrs_i,
  input  logic [25:0] jumpaddr_i,
  output logic [31:0] pc4_o,
  output logic [31:0] npc_o,
  output logic        npc_ok_o
);

  localparam logic [31:0] MaxPc = 32'(ImemBytes - 4);

  assign pc4_o = pc_i + 32'd4;

  always_comb begin
    npc_o = pc4_o;
    unique case (pcsrc_e'(pcsrc_i))
      PCSRC_NEXT:   npc_o = pc4_o;
      // Immediate is a word offset; the top two bits fall off the shift.
      PCSRC_BRANCH: npc_o = pc4_o + {immediate_i[29:0], 2'b00};
      PCSRC_REG:    npc_o = regrs_i;
      PCSRC_JUMP:   npc_o = {pc4_o[31:28], jumpaddr_i, 2'b00};
      default:      npc_o = pc4_o;
    endcase
  end

  assign npc_ok_o = (npc_o[1:0] == 2'b00) && (npc_o <= MaxPc);

endmodule

// File: rtl/pc_ir_fetch.sv
// Program counter, instruction register and fetch FSM for the multiple-cycle CPU.
// A fetch to a misaligned or out-of-range target parks the block in FAULT until reset.
module pc_ir_fetch
  import pc_ir_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = IMEM_SIZE
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] Immediate,
  input  logic [31:0] RegRs,
  input  logic [25:0] JumpAddr,
  input  logic        IRWre,
  input  logic [31:0] IDataIn,
  output logic [31:0] IAddr,
  output logic        InsMemRW,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] IR,
  output logic        Fault,
  output logic [31:0] FetchCount
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         fault_q, fault_d;
  logic [31:0]  npc;
  logic         npc_ok;

  next_pc_calc #(
    .ImemBytes(IMEM_BYTES)
  ) u_next_pc_calc (
    .pc_i        (pc_q),
    .pcsrc_i     (PCSrc),
    .immediate_i (Immediate),
    .regrs_i     (RegRs),
    .jumpaddr_i  (JumpAddr),
    .pc4_o       (PC4),
    .npc_o       (npc),
    .npc_ok_o    (npc_ok)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        // IR loads from the old PC even when the PC update faults.
        if (IRWre) begin
          ir_d  = IDataIn;
          cnt_d = cnt_q + 32'd1;
        end
        if (PCWre) begin
          if (npc_ok) begin
            pc_d = npc;
          end else begin
            fault_d = 1'b1;
            state_d = StFault;
          end
        end
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      cnt_q   <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign PC         = pc_q;
  assign IAddr      = pc_q;
  assign IR         = ir_q;
  assign FetchCount = cnt_q;
  assign Fault      = fault_q;
  assign InsMemRW   = (state_q == StRun);

endmodule

// File: tb/tb_pc_ir_fetch.sv
// Scoreboard bench for pc_ir_fetch: a behavioural fetch model pushes expected state,
// a monitor pops and compares it against the DUT outputs.
module tb_pc_ir_fetch;

  localparam int unsigned MEM = 100;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        PCWre = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] Immediate = '0;
  logic [31:0] RegRs = '0;
  logic [25:0] JumpAddr = '0;
  logic        IRWre = 1'b0;
  logic [31:0] IDataIn = '0;
  logic [31:0] IAddr, PC, PC4, IR, FetchCount;
  logic        InsMemRW, Fault;

  pc_ir_fetch dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .PCWre      (PCWre),
    .PCSrc      (PCSrc),
    .Immediate  (Immediate),
    .RegRs      (RegRs),
    .JumpAddr   (JumpAddr),
    .IRWre      (IRWre),
    .IDataIn    (IDataIn),
    .IAddr      (IAddr),
    .InsMemRW   (InsMemRW),
    .PC         (PC),
    .PC4        (PC4),
    .IR         (IR),
    .Fault      (Fault),
    .FetchCount (FetchCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] cnt;
    logic        fault;
    logic        rw;
    string       tag;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 = idle, 1 = run, 2 = fault.
  int          m_mode;
  logic [31:0] m_pc, m_ir, m_cnt;
  logic        m_fault;

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.pc = m_pc; e.ir = m_ir; e.cnt = m_cnt; e.fault = m_fault;
    e.rw = (m_mode == 1); e.tag = tag;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK or sample_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "PC", PC, e.pc);
        chk(e.tag, "IAddr", IAddr, e.pc);
        chk(e.tag, "PC4", PC4, e.pc + 32'd4);
        chk(e.tag, "IR", IR, e.ir);
        chk(e.tag, "FetchCount", FetchCount, e.cnt);
        chk(e.tag, "Fault", {31'b0, Fault}, {31'b0, e.fault});
        chk(e.tag, "InsMemRW", {31'b0, InsMemRW}, {31'b0, e.rw});
      end
    end
  end

  // Assumes the caller sits just after a falling edge.
  task automatic do_reset(input string tag);
    #1 Reset = 1'b0;
    m_mode = 0; m_pc = 32'h0; m_ir = 32'h0; m_cnt = 32'h0; m_fault = 1'b0;
    push_exp(tag);
    #1 -> sample_ev;
    @(negedge CLK);
    #1 Reset = 1'b1;
  endtask

  task automatic step(input string tag, input logic pw, input logic iw, input logic [1:0] src,
                      input logic [31:0] imm, input logic [31:0] rs, input logic [25:0] j,
                      input logic [31:0] data);
    logic [31:0] p4, npc;
    PCWre = pw; IRWre = iw; PCSrc = src; Immediate = imm; RegRs = rs; JumpAddr = j;
    IDataIn = data;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      p4 = m_pc + 4;
      case (src)
        2'd0:    npc = p4;
        2'd1:    npc = p4 + imm * 4;
        2'd2:    npc = rs;
        default: npc = (p4 & 32'hF000_0000) | ({6'b0, j} << 2);
      endcase
      if (iw) begin
        m_ir  = data;
        m_cnt = m_cnt + 1;
      end
      if (pw) begin
        if (npc % 4 == 0 && npc <= MEM - 4) begin
          m_pc = npc;
        end else begin
          m_fault = 1'b1;
          m_mode  = 2;
        end
      end
    end
    push_exp(tag);
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] imm, rs;
    @(negedge CLK);
    do_reset("reset");
    step("idle", 1'b1, 1'b1, 2'b00, '0, '0, '0, 32'hDEAD_BEEF);
    step("run0", 1'b0, 1'b0, 2'b00, '0, '0, '0, 32'h0);
    for (int i = 0; i < 3; i++)
      step("seq", 1'b1, 1'b1, 2'b00, '0, '0, '0, 32'h2001_0008);
    step("jr8", 1'b1, 1'b1, 2'b10, '0, 32'h8, '0, 32'h1111_2222);
    step("br_back", 1'b1, 1'b0, 2'b01, 32'hFFFF_FFFE, '0, '0, 32'h0);
    step("br_fwd", 1'b1, 1'b0, 2'b01, 32'h2, '0, '0, 32'h0);
    step("jump", 1'b1, 1'b0, 2'b11, '0, '0, 26'h5, 32'h0);
    step("jr64", 1'b1, 1'b0, 2'b10, '0, 32'h40, '0, 32'h0);
    step("mis", 1'b1, 1'b1, 2'b10, '0, 32'h62, '0, 32'h3333_4444);
    step("frozen", 1'b1, 1'b1, 2'b00, '0, '0, '0, 32'h5555_6666);
    step("frozen2", 1'b1, 1'b1, 2'b10, '0, 32'h10, '0, 32'h7777_8888);
    do_reset("async_rst");
    step("idle2", 1'b0, 1'b0, 2'b00, '0, '0, '0, 32'h0);
    step("oor", 1'b1, 1'b0, 2'b10, '0, 32'h64, '0, 32'h0);
    step("frozen3", 1'b1, 1'b1, 2'b00, '0, '0, '0, 32'h9999_AAAA);

    do_reset("rand_rst");
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset("rand_rst");
      imm = 32'($signed($urandom_range(0, 12)) - 6);
      rs  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 24) * 4);
      step("rand", ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), imm, rs, 26'($urandom_range(0, 30)), $urandom);
    end

    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ir_fetch.md
Name: pc_ir_fetch

Overview:
- Fetch-side companion to the instruction memory in the multiple-cycle CPU.
- Holds the program counter and drives the byte address and read enable into the instruction memory.
- Computes the next PC from the control unit's PC-source select.
- Latches the returned 32-bit instruction word into the instruction register (IR) for the decode stage, and flags out-of-range or misaligned fetch targets.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_BYTES, 100: instruction memory size in bytes. Legal PCs satisfy PC <= IMEM_BYTES-4.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- PCWre  input  1  PC write enable from the control unit.
- PCSrc  input  2  next-PC select: 00 PC+4, 01 branch, 10 register, 11 jump.
- Immediate  input  32  sign-extended 16-bit branch offset, in words.
- RegRs  input  32  rs register value (jr target).
- JumpAddr  input  26  instr[25:0] jump field.
- IRWre  input  1  IR write enable from the control unit.
- IDataIn  input  32  instruction word from the instruction memory.
- IAddr  output  32  byte address to the instruction memory; equals PC.
- InsMemRW  output  1  instruction memory read enable (1 = read).
- PC  output  32  current program counter.
- PC4  output  32  PC+4, combinational (for jal link and decode).
- IR  output  32  instruction register.
- Fault  output  1  sticky fetch-fault flag.
- FetchCount  output  32  number of IR loads since reset.

Behaviour:
- FSM states: IDLE, RUN, FAULT.
- Reset low (asynchronous, any time, including mid-operation):
  - state=IDLE, PC=RESET_PC, IR=0, Fault=0, FetchCount=0, InsMemRW=0.
  - IAddr follows PC combinationally, so it equals RESET_PC.
- IDLE:
  - InsMemRW=0; PCWre and IRWre are ignored.
  - Moves to RUN on the first rising edge with Reset high.
  - This gives the memory one settle cycle.
- RUN:
  - InsMemRW=1 combinationally from state.
  - IAddr=PC at all times; the instruction memory read is combinational, so IDataIn is valid in the same cycle.
- Next-PC calculation (NPC), combinational, all 32-bit, wrap on overflow:
  - 00: PC+4.
  - 01: PC+4 + (Immediate<<2).
  - 10: RegRs.
  - 11: {PC4[31:28], JumpAddr, 2'b00}.
- Rising edge in RUN with PCWre=1:
  - If NPC[1:0]==0 and NPC <= IMEM_BYTES-4: PC <= NPC.
  - Otherwise PC holds, Fault <= 1, state <= FAULT.
- Rising edge in RUN with IRWre=1: IR <= IDataIn and FetchCount <= FetchCount+1 (wraps at 2^32).
- PCWre and IRWre in the same cycle:
  - IR captures the word at the old PC.
  - PC advances on the same edge.
  - If NPC faults, the IR load still occurs.
- FAULT:
  - InsMemRW=0; PC, IR and FetchCount are frozen; Fault=1.
  - Only reset exits this state.
- Enables with PCWre=0 and IRWre=0: all state holds.
- Outputs are never X after reset.

Decomposition:
- Shared CPU package holds:
  - PCSrc encodings: PCSRC_NEXT=2'b00, PCSRC_BRANCH=2'b01, PCSRC_REG=2'b10, PCSRC_JUMP=2'b11.
  - FSM state encodings: IDLE, RUN, FAULT.
  - Instruction memory size constant, shared with the instruction memory.
- One sub-module, next_pc_calc: purely combinational NPC generation plus the legality check. Its outputs are NPC and npc_ok.
- The FSM, PC register, IR and counter stay in pc_ir_fetch.

Test Plan:
1. Reset low, then release; hold PCWre=IRWre=0. Required: IDLE for one edge; PC=IAddr=0, InsMemRW=0, then InsMemRW=1 in RUN; IR=0, Fault=0.
2. RUN, IDataIn=32'h2001_0008, PCWre=IRWre=1, PCSrc=00 for three edges. Required: PC goes 4, 8, 12; IR=32'h2001_0008; FetchCount=3.
3. Branches at PC=8:
   - PCSrc=01, Immediate=32'hFFFF_FFFE. Required: PC=4.
   - Then PCSrc=01, Immediate=2 at PC=4. Required: PC=16.
4. PCSrc=11, JumpAddr=26'h0000_005. Required: PC=20. Then PCSrc=10, RegRs=32'h0000_0040. Required: PC=64, no fault.
5. Fault cases:
   - PCSrc=10, RegRs=32'h0000_0062. Required: PC holds, Fault=1, InsMemRW=0; later PCWre/IRWre pulses change nothing.
   - Separately, RegRs=32'h0000_0064 (above 96). Required: same fault response.
6. Reset asserted asynchronously mid-cycle while in FAULT with FetchCount=5. Required: immediately PC=0, IR=0, Fault=0, FetchCount=0, InsMemRW=0, without waiting for a clock edge.
